// File: rtl/uart_rx_core_if.sv
// Frame handshake between the UART receive engine and its bus-side consumer.
interface uart_rx_core_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 parity_error;
   logic                 framing_error;
   logic                 overrun;

   // Receive engine side: produces frames, observes consumer acceptance.
   modport master (
      output data, valid, parity_error, framing_error, overrun,
      input  ready
   );

   // Consumer side: takes frames and drives acceptance.
   modport slave (
      input  data, valid, parity_error, framing_error, overrun,
      output ready
   );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx, finds the start bit, majority-samples
// each bit around mid-period on the oversample strobe, checks parity/stop and
// hands completed frames to the consumer over a valid/ready interface.
module uart_rx_core #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter bit          PARITY_EN   = 1'b0,
   parameter bit          PARITY_ODD  = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sync_reset_i,
   input  logic           rx_tick_i,
   input  logic           rx_i,
   output logic           busy_o,
   uart_rx_core_if.master frame_o
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam int unsigned HALF   = OVERSAMPLE / 2;

   localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(HALF - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(HALF);
   localparam logic [TICK_W-1:0] TICK_POST = TICK_W'(HALF + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [1:0]             samp_q, samp_d;
   logic                   pbit_q, pbit_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   busy_q, busy_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   logic                   rx_sync;
   logic                   maj_c;
   logic                   complete_c;
   logic                   stop_bit_c;

   // Metastability synchroniser for the asynchronous serial line; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else if (sync_reset_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      end
   end

   assign rx_sync = sync_q[SYNC_STAGES-1];

   // Two-of-three vote over the samples at mid-1, mid and the current mid+1 tick.
   assign maj_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);

   // Frame FSM next state; everything advances only on oversample ticks.
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      samp_d     = samp_q;
      pbit_d     = pbit_q;
      complete_c = 1'b0;
      stop_bit_c = 1'b1;

      if (rx_tick_i) begin
         if (state_q != ST_IDLE) begin
            tick_d = tick_q + TICK_W'(1);
            if (tick_q == TICK_PRE) samp_d[0] = rx_sync;
            if (tick_q == TICK_MID) samp_d[1] = rx_sync;
         end

         case (state_q)
            ST_IDLE: begin
               // The detecting tick is tick 0, so the next tick is 1.
               if (!rx_sync) begin
                  state_d = ST_START;
                  tick_d  = TICK_W'(1);
               end
            end
            ST_START: begin
               if (tick_q == TICK_POST && maj_c) begin
                  state_d = ST_IDLE;
                  tick_d  = '0;
               end else if (tick_q == TICK_LAST) begin
                  state_d = ST_DATA;
                  bit_d   = '0;
               end
            end
            ST_DATA: begin
               if (tick_q == TICK_POST) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
               if (tick_q == TICK_LAST) begin
                  if (bit_q == BIT_LAST) begin
                     state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick_q == TICK_POST) pbit_d = maj_c;
               if (tick_q == TICK_LAST) state_d = ST_STOP;
            end
            ST_STOP: begin
               if (tick_q == TICK_POST) begin
                  complete_c = 1'b1;
                  stop_bit_c = maj_c;
                  state_d    = maj_c ? ST_IDLE : ST_BREAK;
                  tick_d     = '0;
               end
            end
            ST_BREAK: begin
               // A line held low must return high before a new start is accepted.
               if (rx_sync) begin
                  state_d = ST_IDLE;
                  tick_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               tick_d  = '0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Output frame register: load on completion unless an unaccepted frame is held.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (valid_q && frame_o.ready) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (complete_c) begin
         if (!valid_q || frame_o.ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = PARITY_EN & ((^shift_q) ^ pbit_q ^ PARITY_ODD);
            ferr_d  = ~stop_bit_c;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         samp_q  <= '0;
         pbit_q  <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (sync_reset_i) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         samp_q  <= '0;
         pbit_q  <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         samp_q  <= samp_d;
         pbit_q  <= pbit_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign busy_o                = busy_q;
   assign frame_o.data          = data_q;
   assign frame_o.valid         = valid_q;
   assign frame_o.parity_error  = perr_q;
   assign frame_o.framing_error = ferr_q;
   assign frame_o.overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E1 instance, serial frames
// built from byte values, expected frames queued and checked by a monitor.
module tb_uart_rx_core;

   localparam int unsigned OS = 16;
   localparam int unsigned DB = 8;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ovr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic sync_reset;
   logic rx_tick;
   logic rx_a;
   logic rx_b;
   logic busy_a;
   logic busy_b;

   int tick_div = 1;
   int tick_ph  = 0;
   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int frame_start_cyc = 0;
   int last_a_cyc = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   uart_rx_core_if #(.DATA_BITS(DB)) bus_a ();
   uart_rx_core_if #(.DATA_BITS(DB)) bus_b ();

   uart_rx_core #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
   ) dut_a (
      .clk(clk), .rst(rst), .sync_reset_i(sync_reset), .rx_tick_i(rx_tick),
      .rx_i(rx_a), .busy_o(busy_a), .frame_o(bus_a.master)
   );

   uart_rx_core #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
   ) dut_b (
      .clk(clk), .rst(rst), .sync_reset_i(sync_reset), .rx_tick_i(rx_tick),
      .rx_i(rx_b), .busy_o(busy_b), .frame_o(bus_b.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Oversample strobe: one tick every tick_div clocks.
   always @(negedge clk) begin
      if (tick_ph + 1 >= tick_div) begin
         rx_tick = 1'b1;
         tick_ph = 0;
      end else begin
         rx_tick = 1'b0;
         tick_ph = tick_ph + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] d, input logic fe, input logic ovr);
      exp_t e;
      e.d = d; e.pe = 1'b0; e.fe = fe; e.ovr = ovr;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [7:0] d, input logic pe);
      exp_t e;
      e.d = d; e.pe = pe; e.fe = 1'b0; e.ovr = 1'b0;
      q_b.push_back(e);
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   task automatic hold_ticks(input int n);
      repeat (n * tick_div) @(negedge clk);
   endtask

   // Line-order bit sequence; with glitch, every '1' bit dips low for one tick at offset 8.
   task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         if (glitch && bits[i]) begin
            set_rx(sel, 1'b1); hold_ticks(8);
            set_rx(sel, 1'b0); hold_ticks(1);
            set_rx(sel, 1'b1); hold_ticks(OS - 9);
         end else begin
            set_rx(sel, bits[i]);
            hold_ticks(OS);
         end
      end
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                             input logic pbit, input logic stop, input bit glitch);
      logic [15:0] bits;
      int n;
      bits      = '0;
      bits[8:1] = d;
      n = 9;
      if (par_en) begin
         bits[9] = pbit;
         n = 10;
      end
      bits[n] = stop;
      n++;
      frame_start_cyc = cyc;
      send_bits(sel, bits, n, glitch);
   endtask

   // Monitor: every accepted frame must match the head of its scoreboard queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (bus_a.valid && bus_a.ready) begin
            if (q_a.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_unexpected_frame: data=0x%0h with nothing expected", bus_a.data);
            end else begin
               e = q_a.pop_front();
               last_a_cyc = cyc;
               chk("a_data", 32'(bus_a.data), 32'(e.d));
               chk("a_parity_error", 32'(bus_a.parity_error), 32'(e.pe));
               chk("a_framing_error", 32'(bus_a.framing_error), 32'(e.fe));
               chk("a_overrun", 32'(bus_a.overrun), 32'(e.ovr));
            end
         end
         if (bus_b.valid && bus_b.ready) begin
            if (q_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected_frame: data=0x%0h with nothing expected", bus_b.data);
            end else begin
               e = q_b.pop_front();
               chk("b_data", 32'(bus_b.data), 32'(e.d));
               chk("b_parity_error", 32'(bus_b.parity_error), 32'(e.pe));
               chk("b_framing_error", 32'(bus_b.framing_error), 32'(e.fe));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       pb;
      int         lat;

      rst = 1'b1; sync_reset = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      bus_a.ready = 1'b1; bus_b.ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_valid", 32'(bus_a.valid), 0);
      chk("rst_data", 32'(bus_a.data), 0);
      chk("rst_flags", 32'({bus_a.parity_error, bus_a.framing_error, bus_a.overrun}), 0);
      chk("rst_b_valid", 32'({busy_b, bus_b.valid}), 0);
      rst = 1'b0;
      hold_ticks(4);

      // 8N1 0x55: valid one clock after tick 153 of the frame.
      push_a(8'h55, 1'b0, 1'b0);
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("latency_55", 32'(last_a_cyc - frame_start_cyc), 156);
      chk("busy_after_55", 32'(busy_a), 0);

      // False start: low for 4 ticks only.
      set_rx(1'b0, 1'b0); hold_ticks(4);
      set_rx(1'b0, 1'b1); hold_ticks(2);
      chk("false_start_busy", 32'(busy_a), 1);
      hold_ticks(14);
      chk("false_start_idle", 32'(busy_a), 0);
      push_a(8'hA3, 1'b0, 1'b0);
      send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0);

      // Stop bit low then line held low: one framing-error frame, then recovery.
      push_a(8'h0F, 1'b1, 1'b0);
      send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
      hold_ticks(40);
      chk("break_busy", 32'(busy_a), 1);
      set_rx(1'b0, 1'b1); hold_ticks(4);
      chk("break_release", 32'(busy_a), 0);
      push_a(8'h81, 1'b0, 1'b0);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);

      // Back-pressure: second frame dropped, overrun shown with the first.
      bus_a.ready = 1'b0;
      push_a(8'h12, 1'b0, 1'b1);
      send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_ticks(2);
      send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_ticks(2);
      chk("ovr_valid", 32'(bus_a.valid), 1);
      chk("ovr_data", 32'(bus_a.data), 32'h12);
      chk("ovr_flag", 32'(bus_a.overrun), 1);
      bus_a.ready = 1'b1;
      @(negedge clk);
      chk("ovr_cleared_valid", 32'(bus_a.valid), 0);
      chk("ovr_cleared_flag", 32'(bus_a.overrun), 0);

      // One-tick glitches inside '1' bits are voted out.
      push_a(8'hA5, 1'b0, 1'b0);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);

      // Tick every 4 clocks: same frame, roughly 4x latency.
      tick_div = 4;
      hold_ticks(2);
      push_a(8'h5A, 1'b0, 1'b0);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      lat = last_a_cyc - frame_start_cyc;
      chk("latency_div4_range", 32'((lat >= 615) && (lat <= 618)), 1);
      tick_div = 1;
      hold_ticks(2);

      // Async reset in the middle of the data bits abandons the frame.
      send_bits(1'b0, {7'h7F, 8'hC3, 1'b0}, 4, 1'b0);
      chk("mid_data_busy", 32'(busy_a), 1);
      rst = 1'b1;
      set_rx(1'b0, 1'b1);
      #1;
      chk("mid_rst_outputs", 32'({busy_a, bus_a.valid, bus_a.data, bus_a.overrun}), 0);
      @(negedge clk);
      rst = 1'b0;
      hold_ticks(4);
      push_a(8'hC3, 1'b0, 1'b0);
      send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);

      // Synchronous reset mid-frame behaves the same.
      send_bits(1'b0, {7'h7F, 8'h66, 1'b0}, 3, 1'b0);
      sync_reset = 1'b1;
      set_rx(1'b0, 1'b1);
      @(negedge clk);
      chk("sync_rst_outputs", 32'({busy_a, bus_a.valid, bus_a.data}), 0);
      sync_reset = 1'b0;
      hold_ticks(4);

      // Random bytes with random idle gaps.
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom());
         push_a(d, 1'b0, 1'b0);
         send_frame(1'b0, d, 1'b0, 1'b0, 1'b1, 1'b0);
         hold_ticks(int'($urandom_range(0, 20)));
      end

      // Even parity instance: fixed cases then random data/parity bits.
      push_b(8'h07, 1'b1);
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
      push_b(8'h07, 1'b0);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         d  = 8'($urandom());
         pb = 1'($urandom());
         push_b(d, (^d) ^ pb);
         send_frame(1'b1, d, 1'b1, pb, 1'b1, 1'b0);
         hold_ticks(int'($urandom_range(0, 8)));
      end

      for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      chk("scoreboard_a_drained", 32'(q_a.size()), 0);
      chk("scoreboard_b_drained", 32'(q_b.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
